text_console_writer: RTL
========================

# text_console_writer

Character-stream front end for the HDMI text overlay. It accepts ASCII bytes over a valid/ready handshake and tracks a cursor. It converts printable characters and control codes into single-cycle cell writes (`wen`/`write_addr`/`write_data`) that drive the write port of the `nes2hdmi` text buffer, and it handles line wrap, line clearing and screen clearing. It replaces the push-button test pattern writer in the board top level and sits in the `clk` domain, directly upstream of `nes2hdmi`.

## Interface
Parameters:
- `COLS`, 40: characters per row; `COLS*ROWS` ≤ 1024.
- `ROWS`, 25: rows on screen.
- `FILL`, 8'h20: byte written to cleared cells.

Ports:
- `clk` in 1: system clock; same clock as the `nes2hdmi` write port.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: `in_char` is valid.
- `in_ready` out 1: block can accept a byte; high only in IDLE.
- `in_char` in 8: ASCII byte.
- `wen` out 1: one-cycle write strobe to the text buffer.
- `write_addr` out 10: cell address, `row*COLS + col`.
- `write_data` out 8: cell contents.
- `cursor_col` out 6: current column, 0..`COLS`-1.
- `cursor_row` out 5: current row, 0..`ROWS`-1.
- `busy` out 1: asserted in any clearing state; equals `~in_ready`.

## Operation
- **States:** INIT, IDLE, CLRLINE, CLRSCR. INIT behaves as CLRSCR and is entered on reset.
- **Accept rule:** a byte is accepted on a rising edge where `in_valid & in_ready`. Bytes are never dropped while `in_valid` is held and `in_ready` is low.
- **0x20..0x7E (printable):**
  - Write the byte at (row, col).
  - If col < `COLS`-1: col+1.
  - Otherwise: perform a row advance.
- **0x0A (LF):** perform a row advance; no character write.
- **0x0D (CR):** col = 0; no write.
- **0x08 (BS):** if col > 0, col−1 and write `FILL` at the new position. At col 0 it is a no-op; it never moves up a row.
- **0x0C (FF):** enter CLRSCR; cursor goes to (0,0).
- **Any other byte:** accepted and ignored; no write, cursor unchanged.
- **Row advance:**
  - col = 0.
  - row = (row == `ROWS`-1) ? 0 : row+1; the screen does not scroll.
  - Enter CLRLINE, which writes `FILL` to all `COLS` cells of the new row in ascending address order, then returns to IDLE.
- **CLRSCR/INIT:** writes `FILL` to addresses 0..`COLS*ROWS`-1 in ascending order, then goes to IDLE with cursor (0,0).
- **Address arithmetic:** `row*COLS + col`, computed at 10 bits; no overflow given the parameter limit. Clear counters are sized for `COLS*ROWS`.

## Timing
- **Cycle numbering:** cycle k is the period following rising edge k. All outputs are registered except `in_ready` and `busy`, which decode the state register.
- **Reset values (while `reset` is high):**
  - `wen`=0, `write_addr`=0, `write_data`=0, cursor (0,0).
  - State INIT with clear counter 0; `in_ready`=0.
- **After reset:** for the first edge R with `reset` low, INIT writes appear in cycles R..R+`COLS*ROWS`-1, one cell per cycle with `wen`=1. `in_ready` rises in cycle R+`COLS*ROWS`.
- **Printable, no wrap (accepted at edge N):**
  - `wen`=1 with address/data in cycle N only.
  - Cursor is updated in cycle N.
  - `in_ready` stays high, giving one character per cycle back-to-back.
- **Row advance (accepted at edge N):**
  - Any character write occurs in cycle N.
  - Clear writes occur in cycles N+1..N+`COLS`.
  - `in_ready`=0 in cycles N..N+`COLS`-1 and rises in cycle N+`COLS`.
- **FF (accepted at edge N):** `wen`=0 in cycle N; clear writes in cycles N+1..N+`COLS*ROWS`; `in_ready` returns in cycle N+`COLS*ROWS`.
- **Between writes:** `wen` is low in every cycle with no write; `write_addr`/`write_data` hold their last values.
- **Reset mid-operation:** any state aborts immediately and the block restarts at INIT; a partial clear is not resumed.

## Test plan
- **Reset clear:** hold `reset` for 3 cycles, then release → exactly 1000 `wen` pulses at addresses 0..999 with data 0x20. `in_ready` rises on the cycle after the last write; cursor (0,0).
- **Basic text:** send "HI" back-to-back → writes (0,0x48) then (1,0x49) in consecutive cycles; `in_ready` never drops; cursor (0,2).
- **Wrap and clear:**
  - Place the cursor at col 39, row 24 and send 'Z' → write (999,0x5A).
  - Then 40 `FILL` writes at addresses 0..39 and cursor (0,0).
  - `in_ready` is low for exactly 40 cycles.
- **Control codes:**
  - At (3,5) send BS → write (124,0x20), cursor (3,4).
  - BS at col 0 → no write.
  - CR → col 0, no write.
  - 0x07 → no effect.
- **Stalled upstream:** hold `in_valid` with 'A' during a CLRLINE → 'A' is accepted on the first cycle `in_ready` is high and written exactly once.
- **Reset mid-clear:** send FF, assert `reset` after 100 clear writes → `wen` drops immediately. After release, a full 1000-cell INIT clear runs starting at address 0.

Source files
------------

// File: rtl/text_console_writer.sv
// Character-stream front end for the HDMI text overlay: turns an ASCII byte
// stream into single-cycle text-buffer cell writes with cursor, wrap and clears.
module text_console_writer #(
  parameter int         COLS = 40,
  parameter int         ROWS = 25,
  parameter logic [7:0] FILL = 8'h20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_char,
  output logic       wen,
  output logic [9:0] write_addr,
  output logic [7:0] write_data,
  output logic [5:0] cursor_col,
  output logic [4:0] cursor_row,
  output logic       busy
);
  localparam int TOTAL = COLS * ROWS;

  typedef enum logic [1:0] {INIT, IDLE, CLRLINE, CLRSCR} state_t;

  state_t      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic        wen_q, wen_d;
  logic [9:0]  addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [5:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  logic        adv;

  function automatic logic [9:0] cell_addr(input logic [4:0] row, input logic [10:0] col);
    return 10'(32'(row) * COLS + 32'(col));
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      cnt_q   <= '0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wen_d   = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    col_d   = col_q;
    row_d   = row_q;
    adv     = 1'b0;
    case (state_q)
      INIT, CLRSCR: begin
        if (cnt_q < 11'(TOTAL)) begin
          wen_d  = 1'b1;
          addr_d = cnt_q[9:0];
          data_d = FILL;
          cnt_d  = cnt_q + 11'd1;
        end
        // An FF clear releases on its final write; INIT adds one settle cycle
        // after its final write before accepting input.
        if ((state_q == CLRSCR && cnt_q == 11'(TOTAL - 1)) || cnt_q == 11'(TOTAL))
          state_d = IDLE;
      end
      CLRLINE: begin
        wen_d  = 1'b1;
        addr_d = cell_addr(row_q, cnt_q);
        data_d = FILL;
        cnt_d  = cnt_q + 11'd1;
        if (cnt_q == 11'(COLS - 1)) state_d = IDLE;
      end
      IDLE: begin
        if (in_valid) begin
          if (in_char >= 8'h20 && in_char <= 8'h7E) begin
            wen_d  = 1'b1;
            addr_d = cell_addr(row_q, {5'd0, col_q});
            data_d = in_char;
            if (col_q == 6'(COLS - 1)) adv = 1'b1;
            else col_d = col_q + 6'd1;
          end else begin
            case (in_char)
              8'h0A: adv = 1'b1;
              8'h0D: col_d = '0;
              8'h08: begin
                if (col_q != 6'd0) begin
                  col_d  = col_q - 6'd1;
                  wen_d  = 1'b1;
                  addr_d = cell_addr(row_q, {5'd0, 6'(col_q - 6'd1)});
                  data_d = FILL;
                end
              end
              8'h0C: begin
                state_d = CLRSCR;
                cnt_d   = '0;
                col_d   = '0;
                row_d   = '0;
              end
              default: ;
            endcase
          end
        end
      end
      default: state_d = INIT;
    endcase

    // Row advance: the screen never scrolls, the new row is wiped instead.
    if (adv) begin
      col_d   = '0;
      row_d   = (row_q == 5'(ROWS - 1)) ? 5'd0 : row_q + 5'd1;
      state_d = CLRLINE;
      cnt_d   = '0;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign busy       = ~in_ready;
  assign wen        = wen_q;
  assign write_addr = addr_q;
  assign write_data = data_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;
endmodule
